// File: rtl/addsub_acc_pipe.sv
// ---------------------------------------------------------------------------
// addsub_acc_pipe
//   Two-stage valid/ready pipeline performing ADD, SUB, ACC (running
//   accumulator) and LOAD (accumulator preset) on WIDTH-bit operands.
//   Stage S1 captures the request; stage S2 holds the registered result.
//
// Ports
//   CLK        clock, all state on rising edge
//   RESET      synchronous, active-high reset
//   in_valid   request present            in_ready   request accepted this cycle
//   op         00 ADD, 01 SUB, 10 ACC, 11 LOAD
//   z, x       operands                    CIN        carry-in (ADD only)
//   out_valid  result present              out_ready  downstream accepts result
//   a          result                      cout       carry-out (SUB: 1 = no borrow)
//   ovf        two's-complement signed overflow
// ---------------------------------------------------------------------------
module addsub_acc_pipe #(
    parameter int WIDTH = 32'sd8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] z,
    input  logic [WIDTH-1:0] x,
    input  logic             CIN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    // Result of one operation, packed as {ovf, cout, a}.  The adder is shared
    // by ADD, SUB and ACC; only the two addends and the carry-in differ.
    function automatic logic [WIDTH+1:0] calc(
        input logic [1:0]       f_op,
        input logic [WIDTH-1:0] f_z,
        input logic [WIDTH-1:0] f_x,
        input logic             f_cin,
        input logic [WIDTH-1:0] f_acc
    );
        logic [WIDTH-1:0] add1;
        logic [WIDTH-1:0] add2;
        logic             cin_eff;
        logic [WIDTH:0]   sum;
        logic             v;
        add1    = f_z;
        add2    = f_x;
        cin_eff = f_cin;
        case (op_e'(f_op))
            OP_ADD: begin
                add1    = f_z;
                add2    = f_x;
                cin_eff = f_cin;
            end
            OP_SUB: begin
                add1    = f_z;
                add2    = ~f_x;
                cin_eff = 1'b1;
            end
            OP_ACC: begin
                add1    = f_acc;
                add2    = f_x;
                cin_eff = 1'b0;
            end
            default: begin
                add1    = f_z;
                add2    = f_x;
                cin_eff = 1'b0;
            end
        endcase
        sum = {1'b0, add1} + {1'b0, add2} + {{WIDTH{1'b0}}, cin_eff};
        // Same-sign addends producing a different-sign result.
        v   = (add1[WIDTH-1] == add2[WIDTH-1]) && (sum[WIDTH-1] != add1[WIDTH-1]);
        if (op_e'(f_op) == OP_LOAD) begin
            calc = {1'b0, 1'b0, f_x};
        end else begin
            calc = {v, sum[WIDTH], sum[WIDTH-1:0]};
        end
    endfunction

    // Stage S1
    logic             s1_valid_r;
    logic [1:0]       s1_op_r;
    logic [WIDTH-1:0] s1_z_r;
    logic [WIDTH-1:0] s1_x_r;
    logic             s1_cin_r;
    // Stage S2 and accumulator
    logic             out_valid_r;
    logic [WIDTH-1:0] a_r;
    logic             cout_r;
    logic             ovf_r;
    logic [WIDTH-1:0] acc_r;
    // Control / datapath
    logic             advance_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [WIDTH-1:0] res_a_s;
    logic             res_cout_s;
    logic             res_ovf_s;
    logic             acc_wr_s;

    // Handshake control and S1 -> S2 result computation.
    always_comb begin
        advance_s  = 1'b0;
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        acc_wr_s   = 1'b0;
        advance_s  = s1_valid_r && (!out_valid_r || out_ready);
        // Reset gating keeps in_ready low while RESET is high; in_valid never
        // feeds back into in_ready.
        if (RESET) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = !s1_valid_r || advance_s;
        end
        accept_s = in_valid && in_ready_s;
        acc_wr_s = advance_s && (s1_op_r[1] == 1'b1);
        {res_ovf_s, res_cout_s, res_a_s} = calc(s1_op_r, s1_z_r, s1_x_r, s1_cin_r, acc_r);
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign a         = a_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

    // Stage S1 capture register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 2'b00;
            s1_z_r     <= '0;
            s1_x_r     <= '0;
            s1_cin_r   <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_op_r    <= op;
            s1_z_r     <= z;
            s1_x_r     <= x;
            s1_cin_r   <= CIN;
        end else if (advance_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage S2 result register; holds while the result is stalled.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_r <= 1'b0;
            a_r         <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= 1'b1;
            a_r         <= res_a_s;
            cout_r      <= res_cout_s;
            ovf_r       <= res_ovf_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Accumulator: written only as an ACC/LOAD moves into S2, so the next
    // ACC sitting in S1 sees the new value one cycle later without a stall.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_r <= '0;
        end else if (acc_wr_s) begin
            acc_r <= res_a_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: tb/tb_addsub_acc_pipe.sv
module tb_addsub_acc_pipe;

    logic        CLK;
    logic        RESET;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] z;
    logic [31:0] x;
    logic        CIN;
    logic        out_ready;

    logic        in_ready8, out_valid8, cout8, ovf8;
    logic [7:0]  a8;
    logic        in_ready32, out_valid32, cout32, ovf32;
    logic [31:0] a32;

    int errors = 0;
    int checks = 0;

    logic [33:0] q8[$];
    logic [33:0] q32[$];
    longint      macc8  = 64'sd0;
    longint      macc32 = 64'sd0;
    bit          held8  = 1'b0;

    addsub_acc_pipe #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready8),
        .op(op), .z(z[7:0]), .x(x[7:0]), .CIN(CIN),
        .out_valid(out_valid8), .out_ready(out_ready),
        .a(a8), .cout(cout8), .ovf(ovf8)
    );

    addsub_acc_pipe #(.WIDTH(32)) dut32 (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready32),
        .op(op), .z(z), .x(x), .CIN(CIN),
        .out_valid(out_valid32), .out_ready(out_ready),
        .a(a32), .cout(cout32), .ovf(ovf32)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic on plain integers: {ovf, cout, a}.
    function automatic logic [33:0] ref_res(input int w, input logic [1:0] o,
                                            input longint zz, input longint xx,
                                            input bit c, input longint ac);
        longint m, half, sz, sx, sa, u, s, av;
        bit co, ov;
        m    = 64'sd1 << w;
        half = m / 64'sd2;
        sz   = (zz >= half) ? zz - m : zz;
        sx   = (xx >= half) ? xx - m : xx;
        sa   = (ac >= half) ? ac - m : ac;
        co   = 1'b0;
        case (o)
            2'b00: begin u = zz + xx + longint'(c); s = sz + sx + longint'(c); co = (u >= m); end
            2'b01: begin u = zz - xx;               s = sz - sx;               co = (zz >= xx); end
            2'b10: begin u = ac + xx;               s = sa + sx;               co = (u >= m); end
            default: begin u = xx;                  s = 64'sd0;                co = 1'b0; end
        endcase
        av = ((u % m) + m) % m;
        ov = (o != 2'b11) && ((s < -half) || (s >= half));
        ref_res = {ov, co, av[31:0]};
    endfunction

    // Compare process: transfers are judged half a cycle before the edge.
    always @(negedge CLK) begin
        logic [33:0] r;
        if (RESET) begin
            chk("in_ready_in_reset", {63'd0, in_ready8}, 64'd0);
            q8.delete();
            q32.delete();
            macc8  = 64'sd0;
            macc32 = 64'sd0;
            held8  = 1'b0;
        end else begin
            chk("in_ready8",  {63'd0, in_ready8},  {63'd0, (q8.size() < 2) || out_ready});
            chk("in_ready32", {63'd0, in_ready32}, {63'd0, (q32.size() < 2) || out_ready});
            if (held8) chk("hold_valid8", {63'd0, out_valid8}, 64'd1);
            if (out_valid8) begin
                if (q8.size() == 0) chk("spurious8", 64'd1, 64'd0);
                else begin
                    chk("result8", {30'd0, ovf8, cout8, 24'd0, a8}, {30'd0, q8[0]});
                    if (out_ready) void'(q8.pop_front());
                end
            end
            if (out_valid32) begin
                if (q32.size() == 0) chk("spurious32", 64'd1, 64'd0);
                else begin
                    chk("result32", {30'd0, ovf32, cout32, a32}, {30'd0, q32[0]});
                    if (out_ready) void'(q32.pop_front());
                end
            end
            if (in_valid && in_ready8) begin
                r = ref_res(8, op, longint'(z[7:0]), longint'(x[7:0]), CIN, macc8);
                q8.push_back(r);
                if (op[1]) macc8 = longint'(r[7:0]);
            end
            if (in_valid && in_ready32) begin
                r = ref_res(32, op, longint'(z), longint'(x), CIN, macc32);
                q32.push_back(r);
                if (op[1]) macc32 = longint'(r[31:0]);
            end
            held8 = out_valid8 && !out_ready;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic [31:0] zz, input logic [31:0] xx, input logic c);
        in_valid = 1'b1;
        op       = o;
        z        = zz;
        x        = xx;
        CIN      = c;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int budget;
        idle();
        out_ready = 1'b1;
        budget = 40;
        while ((q8.size() != 0 || q32.size() != 0) && budget > 0) begin
            step();
            budget--;
        end
        chk(nm, {32'd0, q8.size() + q32.size()}, 64'd0);
    endtask

    initial begin
        logic [31:0] d[4];
        int n_acc;
        int budget;
        d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33; d[3] = 32'h44;
        RESET = 1'b1; out_ready = 1'b1;
        drive(2'b00, 32'h5, 32'h6, 1'b0);   // must be ignored during reset
        repeat (3) step();
        chk("reset_out_valid", {63'd0, out_valid8}, 64'd0);
        chk("reset_a", {56'd0, a8}, 64'd0);
        RESET = 1'b0;
        idle();
        step();

        // ADD with carry-in wrapping, latency two edges
        drive(2'b00, 32'hFF, 32'h01, 1'b1);
        step(); idle();
        chk("lat1_out_valid", {63'd0, out_valid8}, 64'd0);
        step();
        chk("add_valid", {63'd0, out_valid8}, 64'd1);
        chk("add_a", {56'd0, a8}, 64'h01);
        chk("add_cout_ovf", {62'd0, cout8, ovf8}, 64'd2);

        // SUB overflow and SUB borrow
        drive(2'b01, 32'h80, 32'h01, 1'b1);
        step();
        drive(2'b01, 32'h00, 32'h01, 1'b0);
        step(); idle();
        chk("sub1_a", {56'd0, a8}, 64'h7F);
        chk("sub1_cout_ovf", {62'd0, cout8, ovf8}, 64'd3);
        step();
        chk("sub2_a", {56'd0, a8}, 64'hFF);
        chk("sub2_cout_ovf", {62'd0, cout8, ovf8}, 64'd0);

        // LOAD then back-to-back ACCs
        drive(2'b11, 32'hAA, 32'h10, 1'b1);
        step();
        drive(2'b10, 32'hAA, 32'h05, 1'b1);
        step();
        chk("load_a", {56'd0, a8}, 64'h10);
        drive(2'b10, 32'h00, 32'h03, 1'b0);
        step(); idle();
        chk("acc1_a", {56'd0, a8}, 64'h15);
        step();
        chk("acc2_a", {56'd0, a8}, 64'h18);
        chk("acc2_valid", {63'd0, out_valid8}, 64'd1);
        step();

        // Backpressure: two accepted then stall, drain in order
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, d[n_acc], 32'h01, 1'b0);
            if (in_ready8) n_acc++;
            step();
        end
        chk("bp_accepted", {32'd0, n_acc}, 64'd2);
        chk("bp_in_ready", {63'd0, in_ready8}, 64'd0);
        out_ready = 1'b1;
        budget = 20;
        while (n_acc < 4 && budget > 0) begin
            drive(2'b00, d[n_acc], 32'h01, 1'b0);
            if (in_ready8) n_acc++;
            step();
            budget--;
        end
        chk("bp_all_accepted", {32'd0, n_acc}, 64'd4);
        drain("bp_drain");

        // Reset with both stages full and acc = 0x18
        out_ready = 1'b0;
        drive(2'b11, 32'h0, 32'h18, 1'b0);
        step();
        drive(2'b00, 32'h1, 32'h2, 1'b0);
        step();
        chk("full_in_ready", {63'd0, in_ready8}, 64'd0);
        RESET = 1'b1;
        drive(2'b10, 32'h0, 32'h7F, 1'b0);
        step();
        chk("rst_out_valid", {63'd0, out_valid8}, 64'd0);
        chk("rst_a", {56'd0, a8}, 64'd0);
        RESET = 1'b0;
        out_ready = 1'b1;
        drive(2'b10, 32'h0, 32'h01, 1'b0);
        step(); idle();
        step();
        chk("post_rst_acc", {56'd0, a8}, 64'h01);
        chk("post_rst_valid", {63'd0, out_valid8}, 64'd1);
        step();

        // Random stream with random backpressure
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 2'($urandom_range(0, 3));
            z         = $urandom;
            x         = $urandom;
            CIN       = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0080;
            if ($urandom_range(0, 7) == 0) z = 32'hFFFF_FFFF;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/addsub_acc_pipe.md
ADDSUB_ACC_PIPE -- requirements
Module: addsub_acc_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1, reset; it is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, input transaction present.
REQ-005 SHALL have port in_ready, output, 1, block accepts an input this cycle.
REQ-006 SHALL have port op, input, 2, operation: 00 ADD, 01 SUB, 10 ACC, 11 LOAD.
REQ-007 SHALL have port z, input, WIDTH, first operand.
REQ-008 SHALL have port x, input, WIDTH, second operand.
REQ-009 SHALL have port CIN, input, 1, carry-in, used by ADD only.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-012 SHALL have port a, output, WIDTH, result.
REQ-013 SHALL have port cout, output, 1, carry-out of the WIDTH-bit addition.
REQ-014 SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-015 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-016 SHALL implement two register stages: S1 (captured op, z, x, CIN) and S2 (registered a, cout, ovf, out_valid).
REQ-017 SHALL advance S1 into S2 when S1 is valid and (out_valid == 0 or out_ready == 1).
REQ-018 SHALL drive in_ready = !S1_valid || S1 advances this cycle (combinational from out_valid, out_ready, S1_valid only; never from in_valid).
REQ-019 SHALL give latency of exactly 2 cycles from input transfer to out_valid when out_ready is held high; throughput one transaction per cycle.
REQ-020 SHALL, for ADD, compute {cout,a} = z + x + CIN in WIDTH+1 bits.
REQ-021 SHALL, for SUB, compute {cout,a} = z + ~x + 1 (cout = 1 means no borrow); CIN ignored.
REQ-022 SHALL, for ACC, compute {cout,a} = acc + x, and set acc <= a; z and CIN ignored.
REQ-023 SHALL, for LOAD, set a = x, acc <= x, cout = 0, ovf = 0; z and CIN ignored.
REQ-024 SHALL set ovf = 1 when the two effective addends share a sign bit and a's sign bit differs (ADD, SUB with ~x, ACC).
REQ-025 SHALL update acc only in the cycle an ACC/LOAD advances S1 into S2, so back-to-back ACC ops always see the latest acc without stall.
REQ-026 SHALL hold a, cout, ovf, out_valid stable while out_valid && !out_ready.
REQ-027 SHALL leave ADD and SUB results independent of, and without effect on, acc.
REQ-028 SHALL wrap sums modulo 2^WIDTH; no saturation.
REQ-029 SHALL accept a new input in the same cycle the S2 result is consumed when the pipe is full (no bubble).

Reset
REQ-030 SHALL, when RESET is high at a rising edge, clear S1_valid, out_valid, a, cout, ovf and acc to 0, discarding in-flight transactions.
REQ-031 SHALL hold in_ready = 0 while RESET is high and ignore in_valid.
REQ-032 SHALL take RESET over any simultaneous transfer; the first input after reset deasserts is accepted normally.

Verification
REQ-033 SHALL pass: WIDTH=8, ADD z=0xFF x=0x01 CIN=1, out_ready=1 -> 2 cycles later a=0x01 cout=1 ovf=0.
REQ-034 SHALL pass: SUB z=0x80 x=0x01 -> a=0x7F cout=1 ovf=1; SUB z=0x00 x=0x01 -> a=0xFF cout=0 ovf=0.
REQ-035 SHALL pass: LOAD x=0x10, then ACC x=0x05 and ACC x=0x03 on consecutive cycles -> outputs 0x10, 0x15, 0x18 on consecutive cycles.
REQ-036 SHALL pass: 4 back-to-back inputs with out_ready=0 -> in_ready falls after 2 accepted; raising out_ready drains all 4 in order with no loss or duplication.
REQ-037 SHALL pass: RESET asserted with both stages full and acc=0x18 -> next cycle out_valid=0, a=0, acc=0; ACC x=0x01 afterwards yields a=0x01.
REQ-038 SHALL pass: random op/operand stream with random out_ready, WIDTH=8 and WIDTH=32, matching a reference model per transaction.
